// File: rtl/des_round_sequencer.sv
// Iterative DES controller: one round per cycle over NUM_ROUNDS cycles, with the key schedule,
// IP/FP and valid/ready handshakes on both the input and output sides.
module des_round_sequencer #(
  parameter bit          BYPASS_PERM = 1'b0,
  parameter int unsigned NUM_ROUNDS  = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [63:0] i_data_in,
  input  logic [63:0] i_key_in,
  input  logic        i_decrypt,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic [63:0] o_data_out,
  output logic        o_busy,
  output logic [4:0]  o_round_idx
);

  localparam int unsigned IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
  };
  localparam int unsigned FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
  };
  localparam int unsigned E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };
  localparam int unsigned P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  // Each S-box is 64 nibbles, entry 0 in the top nibble; index = {b1, b6, b2..b5}.
  localparam logic [255:0] SBOX_TAB [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [63:0] f_ip(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], x[6'(64 - IP_TAB[i])]};
    return o;
  endfunction

  function automatic logic [63:0] f_fp(input logic [63:0] x);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o = {o[62:0], x[6'(64 - FP_TAB[i])]};
    return o;
  endfunction

  function automatic logic [55:0] f_pc1(input logic [63:0] k);
    logic [55:0] o;
    o = '0;
    for (int i = 0; i < 56; i++) o = {o[54:0], k[6'(64 - PC1_TAB[i])]};
    return o;
  endfunction

  function automatic logic [47:0] f_pc2(input logic [55:0] cd);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[46:0], cd[6'(56 - PC2_TAB[i])]};
    return o;
  endfunction

  function automatic logic [47:0] f_e(input logic [31:0] r);
    logic [47:0] o;
    o = '0;
    for (int i = 0; i < 48; i++) o = {o[46:0], r[5'(32 - E_TAB[i])]};
    return o;
  endfunction

  function automatic logic [31:0] f_p(input logic [31:0] s);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < 32; i++) o = {o[30:0], s[5'(32 - P_TAB[i])]};
    return o;
  endfunction

  function automatic logic [3:0] f_sbox(input logic [255:0] tab, input logic [5:0] b);
    logic [255:0] t;
    t = tab << {b[5], b[0], b[4:1], 2'b00};
    return t[255:252];
  endfunction

  function automatic logic [31:0] f_round(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s;
    x = f_e(r) ^ k;
    s = '0;
    for (int n = 0; n < 8; n++) begin
      s = {s[27:0], f_sbox(SBOX_TAB[n], x[47:42])};
      x = {x[41:0], 6'd0};
    end
    return f_p(s);
  endfunction

  function automatic logic [27:0] f_rotl(input logic [27:0] c, input logic two);
    return two ? {c[25:0], c[27:26]} : {c[26:0], c[27]};
  endfunction

  function automatic logic [27:0] f_rotr(input logic [27:0] c, input logic two);
    return two ? {c[1:0], c[27:2]} : {c[0], c[27:1]};
  endfunction

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e      r_state;
  logic [63:0] r_lr;
  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_decrypt;
  logic [4:0]  r_round_idx;
  logic [63:0] r_data_out;
  logic        r_in_ready;
  logic        r_out_valid;
  logic        r_busy;

  logic        w_enc_single;
  logic        w_dec_single;
  logic [27:0] w_c_rot;
  logic [27:0] w_d_rot;
  logic [47:0] w_subkey;
  logic [31:0] w_f;
  logic [63:0] w_lr_next;
  logic [63:0] w_preout;
  logic [63:0] w_ip;
  logic [63:0] w_fp;
  logic [55:0] w_pc1;
  logic        w_last;

  always_comb begin
    w_enc_single = (r_round_idx == 5'd1) || (r_round_idx == 5'd2) ||
                   (r_round_idx == 5'd9) || (r_round_idx == 5'd16);
    w_dec_single = (r_round_idx == 5'd2) || (r_round_idx == 5'd9) || (r_round_idx == 5'd16);
    w_c_rot      = r_c;
    w_d_rot      = r_d;
    // Decrypt walks the schedule backwards; its first round uses the unrotated C0/D0.
    if (!r_decrypt) begin
      w_c_rot = f_rotl(r_c, !w_enc_single);
      w_d_rot = f_rotl(r_d, !w_enc_single);
    end else if (r_round_idx != 5'd1) begin
      w_c_rot = f_rotr(r_c, !w_dec_single);
      w_d_rot = f_rotr(r_d, !w_dec_single);
    end
    w_subkey  = f_pc2({w_c_rot, w_d_rot});
    w_f       = f_round(r_lr[31:0], w_subkey);
    w_lr_next = {r_lr[31:0], r_lr[63:32] ^ w_f};
    w_preout  = {w_lr_next[31:0], w_lr_next[63:32]};
    w_ip      = BYPASS_PERM ? i_data_in : f_ip(i_data_in);
    w_fp      = BYPASS_PERM ? w_preout : f_fp(w_preout);
    w_pc1     = f_pc1(i_key_in);
    w_last    = (r_round_idx == 5'(NUM_ROUNDS));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_lr        <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_decrypt   <= 1'b0;
      r_round_idx <= '0;
      r_data_out  <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_in_valid) begin
            r_lr        <= w_ip;
            r_c         <= w_pc1[55:28];
            r_d         <= w_pc1[27:0];
            r_decrypt   <= i_decrypt;
            r_round_idx <= 5'd1;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= StRound;
          end
        end
        StRound: begin
          r_lr <= w_lr_next;
          r_c  <= w_c_rot;
          r_d  <= w_d_rot;
          if (w_last) begin
            r_data_out  <= w_fp;
            r_out_valid <= 1'b1;
            r_round_idx <= '0;
            r_state     <= StDone;
          end else begin
            r_round_idx <= r_round_idx + 5'd1;
          end
        end
        StDone: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_data_out  = r_data_out;
  assign o_busy      = r_busy;
  assign o_round_idx = r_round_idx;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: known-answer vector table, backpressure and mid-block reset
// sequences, and random encrypt/decrypt round trips against a plain-arithmetic DES model.
module tb_des_round_sequencer;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [63:0] i_data_in;
  logic [63:0] i_key_in;
  logic        i_decrypt;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [63:0] o_data_out;
  logic        o_busy;
  logic [4:0]  o_round_idx;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  des_round_sequencer dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_data_in   (i_data_in),
    .i_key_in    (i_key_in),
    .i_decrypt   (i_decrypt),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_data_out  (o_data_out),
    .o_busy      (o_busy),
    .o_round_idx (o_round_idx)
  );

  // ---------------- reference model (DES bit 1 = MSB) ----------------
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27, 19, 11, 3,
    60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45, 37,
    29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam logic [255:0] SB [8] = '{
    256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
    256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
    256'hA09E63F51DC7B428D70934A6285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
    256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
    256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
    256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
    256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
    256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B};

  // Bit number pos (1 = MSB) of a w-bit value held in the low bits of x.
  function automatic logic [63:0] m_bit(input logic [63:0] x, input int w, input int pos);
    return (x >> (w - pos)) & 64'd1;
  endfunction

  function automatic logic [63:0] m_ip(input logic [63:0] x);
    logic [63:0] o = '0;
    for (int i = 0; i < 64; i++) o = (o << 1) | m_bit(x, 64, IP_T[i]);
    return o;
  endfunction

  function automatic logic [63:0] m_fp(input logic [63:0] x);
    logic [63:0] o = '0;
    for (int i = 0; i < 64; i++) o = (o << 1) | m_bit(x, 64, FP_T[i]);
    return o;
  endfunction

  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [63:0] e = '0;
    logic [63:0] s = '0;
    logic [63:0] p = '0;
    logic [47:0] x;
    int b, row, col;
    logic [255:0] t;
    for (int i = 0; i < 48; i++) e = (e << 1) | m_bit({32'd0, r}, 32, E_T[i]);
    x = e[47:0] ^ k;
    for (int n = 0; n < 8; n++) begin
      b   = int'((x >> (42 - 6 * n)) & 48'd63);
      row = ((b >> 5) & 1) * 2 + (b & 1);
      col = (b >> 1) & 15;
      t   = SB[n] >> (4 * (63 - (row * 16 + col)));
      s   = (s << 4) | {60'd0, t[3:0]};
    end
    for (int i = 0; i < 32; i++) p = (p << 1) | m_bit(s, 32, P_T[i]);
    return p[31:0];
  endfunction

  function automatic logic [63:0] des_model(input logic [63:0] key, input logic [63:0] data,
                                            input bit dec);
    logic [63:0] cd = '0;
    logic [63:0] kk;
    logic [27:0] c, d;
    logic [47:0] ks [16];
    logic [63:0] ipd;
    logic [31:0] l, r, t;
    int sh;
    for (int i = 0; i < 56; i++) cd = (cd << 1) | m_bit(key, 64, PC1_T[i]);
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      sh = (i == 0 || i == 1 || i == 8 || i == 15) ? 1 : 2;
      c  = (c << sh) | (c >> (28 - sh));
      d  = (d << sh) | (d >> (28 - sh));
      kk = '0;
      for (int j = 0; j < 48; j++) kk = (kk << 1) | m_bit({8'd0, c, d}, 56, PC2_T[j]);
      ks[i] = kk[47:0];
    end
    ipd = m_ip(data);
    l = ipd[63:32];
    r = ipd[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ m_f(r, ks[dec ? 15 - i : i]);
      l = t;
    end
    return m_fp({r, l});
  endfunction

  // ---------------- bench helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Accept one block, then follow it until out_valid; seq_ok tracks round_idx/busy/in_ready.
  task automatic start_block(input logic [63:0] key, input logic [63:0] din, input logic dec,
                             output int lat, output bit seq_ok);
    int guard = 0;
    while (!o_in_ready && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    i_key_in = key; i_data_in = din; i_decrypt = dec; i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    seq_ok = (o_round_idx == 5'd1) && o_busy && !o_in_ready && !o_out_valid;
    lat = 0;
    while (!o_out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
      if (o_out_valid) seq_ok &= (o_round_idx == 5'd0) && o_busy && !o_in_ready;
      else seq_ok &= (o_round_idx == 5'(lat + 1)) && o_busy;
    end
  endtask

  task automatic take_result(input int hold, output logic [63:0] res, output bit stable);
    res = o_data_out;
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      stable &= (o_data_out == res) && o_out_valid && !o_in_ready;
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    stable &= !o_out_valid && o_in_ready && !o_busy;
  endtask

  typedef struct {
    logic [63:0] key;
    logic [63:0] din;
    logic        dec;
    logic [63:0] exp;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [5];
    int          lat;
    bit          ok;
    bit          stable;
    logic [63:0] res, d0, pt, key, ct;

    vecs[0] = '{key: 64'h133457799BBCDFF1, din: 64'h0123456789ABCDEF, dec: 1'b0,
                exp: 64'h85E813540F0AB405};
    vecs[1] = '{key: 64'h133457799BBCDFF1, din: 64'h85E813540F0AB405, dec: 1'b1,
                exp: 64'h0123456789ABCDEF};
    vecs[2] = '{key: 64'h0E329232EA6D0D73, din: 64'h8787878787878787, dec: 1'b0,
                exp: 64'h0000000000000000};
    vecs[3] = '{key: 64'h0E329232EA6D0D73, din: 64'h0000000000000000, dec: 1'b1,
                exp: 64'h8787878787878787};
    vecs[4] = '{key: 64'h0101010101010101, din: 64'h8000000000000000, dec: 1'b0,
                exp: 64'h95F8A5E5DD31D900};

    i_rst_n = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
    i_data_in = '0; i_key_in = '0; i_decrypt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready", 64'(o_in_ready), 64'd1);
    check("reset out_valid", 64'(o_out_valid), 64'd0);
    check("reset busy", 64'(o_busy), 64'd0);
    check("reset round_idx", 64'(o_round_idx), 64'd0);
    check("reset data_out", o_data_out, 64'd0);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      start_block(vecs[v].key, vecs[v].din, vecs[v].dec, lat, ok);
      take_result(0, res, stable);
      check($sformatf("vec%0d data_out", v), res, vecs[v].exp);
      check($sformatf("vec%0d latency", v), 64'(lat), 64'd16);
      check($sformatf("vec%0d round_idx/busy sequence", v), 64'(ok), 64'd1);
      check($sformatf("vec%0d handshake release", v), 64'(stable), 64'd1);
    end

    // Backpressure: ten cycles of out_ready=0 with in_valid pulses that must be ignored.
    start_block(vecs[0].key, vecs[0].din, 1'b0, lat, ok);
    d0 = o_data_out;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      i_in_valid = i[0];
      i_data_in  = {$urandom, $urandom};
      i_decrypt  = 1'($urandom);
      @(posedge clk); #1;
      stable &= (o_data_out == d0) && o_out_valid && !o_in_ready && o_busy;
    end
    i_in_valid = 1'b0;
    check("bp data_out", d0, 64'h85E813540F0AB405);
    check("bp held stable", 64'(stable), 64'd1);
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    i_out_ready = 1'b0;
    check("bp release out_valid", 64'(o_out_valid), 64'd0);
    check("bp release in_ready", 64'(o_in_ready), 64'd1);
    start_block(vecs[1].key, vecs[1].din, 1'b1, lat, ok);
    take_result(0, res, stable);
    check("bp next block", res, 64'h0123456789ABCDEF);
    check("bp next latency", 64'(lat), 64'd16);

    // Reset while round 8 is in flight.
    i_key_in = vecs[2].key; i_data_in = vecs[2].din; i_decrypt = 1'b0; i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    for (int i = 0; i < 30 && o_round_idx != 5'd8; i++) begin
      @(posedge clk); #1;
    end
    check("rst reached round 8", 64'(o_round_idx), 64'd8);
    i_rst_n = 1'b0;
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    check("rst in_ready", 64'(o_in_ready), 64'd1);
    check("rst out_valid", 64'(o_out_valid), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst round_idx", 64'(o_round_idx), 64'd0);
    stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      stable &= !o_out_valid && o_in_ready && (o_data_out == 64'd0);
    end
    check("rst no spurious output", 64'(stable), 64'd1);
    start_block(vecs[2].key, vecs[2].din, 1'b0, lat, ok);
    take_result(1, res, stable);
    check("rst next block", res, 64'h0000000000000000);

    // Random round trips against the model.
    for (int n = 0; n < 1000; n++) begin
      key = {$urandom, $urandom};
      pt  = {$urandom, $urandom};
      start_block(key, pt, 1'b0, lat, ok);
      take_result(int'($urandom_range(0, 2)), ct, stable);
      check($sformatf("rnd%0d enc", n), ct, des_model(key, pt, 1'b0));
      if (lat != 16 || !ok || !stable) check($sformatf("rnd%0d enc timing", n), 64'(lat), 64'd16);
      start_block(key, ct, 1'b1, lat, ok);
      take_result(int'($urandom_range(0, 2)), res, stable);
      check($sformatf("rnd%0d dec", n), res, pt);
      if (lat != 16 || !ok || !stable) check($sformatf("rnd%0d dec timing", n), 64'(lat), 64'd16);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
